// File: rtl/regfile_if.sv
// Port bundle for the MIPS32 register file: one write port, two read ports
// and the debug write counter.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [31:0]       wr_count;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, wr_count
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, wr_count
  );
endinterface

// File: rtl/regfile.sv
// 32 x 32-bit register file with $zero hardwired, two combinational read ports,
// one synchronous write port and a committed-write counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);
  localparam int AW = $clog2(REG_NUM);

  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic [DATA_W-1:0] regs_d [REG_NUM];
  logic [31:0]       wr_count_q;
  logic [31:0]       wr_count_d;
  logic              wr_commit;
  logic [DATA_W-1:0] rdata1_d;
  logic [DATA_W-1:0] rdata2_d;

  // Writes to $zero are dropped entirely, including from the counter.
  assign wr_commit = bus.we && (bus.waddr != '0);

  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      regs_d[i] = regs_q[i];
      if (rst || i == 0) begin
        regs_d[i] = '0;
      end else if (wr_commit && bus.waddr == AW'(i)) begin
        regs_d[i] = bus.wdata;
      end
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (rst) begin
      wr_count_d = '0;
    end else if (wr_commit) begin
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_NUM; i++) begin
      regs_q[i] <= regs_d[i];
    end
    wr_count_q <= wr_count_d;
  end

  // Read ports: reset, enable and $zero force 0 ahead of any bypass.
  always_comb begin
    rdata1_d = '0;
    if (rst || !bus.re1 || bus.raddr1 == '0) begin
      rdata1_d = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (bus.we && bus.waddr == bus.raddr1) begin
      rdata1_d = bus.wdata;
`endif
    end else begin
      rdata1_d = regs_q[bus.raddr1];
    end
  end

  always_comb begin
    rdata2_d = '0;
    if (rst || !bus.re2 || bus.raddr2 == '0) begin
      rdata2_d = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (bus.we && bus.waddr == bus.raddr2) begin
      rdata2_d = bus.wdata;
`endif
    end else begin
      rdata2_d = regs_q[bus.raddr2];
    end
  end

  assign bus.rdata1   = rdata1_d;
  assign bus.rdata2   = rdata2_d;
  assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, randomized traffic
// against an array model, and counter-wrap / reset-collision sequences.
module tb_regfile;
  logic clk;
  logic rst;

  regfile_if rf ();

  regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        r;
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e1;
    logic [4:0]  a1;
    logic        e2;
    logic [4:0]  a2;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] xc;
  } vec_t;

  vec_t        vecs [$];
  logic [31:0] model_regs [32];
  logic [31:0] model_cnt;
  int          tests;
  int          failed;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    @(negedge clk);
    rst       = r;
    rf.we     = w;
    rf.waddr  = wa;
    rf.wdata  = wd;
    rf.re1    = e1;
    rf.raddr1 = a1;
    rf.re2    = e2;
    rf.raddr2 = a2;
  endtask

  // What a read port must show this cycle, given the architectural state.
  function automatic logic [31:0] exp_read(input logic en, input logic [4:0] addr);
    if (rst || !en || addr == 5'd0) return 32'h0;
    if (BYP && rf.we && rf.waddr == addr) return rf.wdata;
    return model_regs[addr];
  endfunction

  // Called just after a rising edge, while the inputs are still held.
  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
      model_cnt = 32'h0;
    end else if (rf.we && rf.waddr != 5'd0) begin
      model_regs[rf.waddr] = rf.wdata;
      model_cnt = model_cnt + 32'd1;
    end
  endtask

  task automatic show(input string tag);
    $display("[TB] %s rst=%0b we=%0b wa=%0d wd=%h re1=%0b a1=%0d re2=%0b a2=%0d | r1=%h r2=%h cnt=%h",
             tag, rst, rf.we, rf.waddr, rf.wdata, rf.re1, rf.raddr1, rf.re2, rf.raddr2,
             rf.rdata1, rf.rdata2, rf.wr_count);
  endtask

  task automatic run_step(input string tag, input logic r, input logic w, input logic [4:0] wa,
                          input logic [31:0] wd, input logic e1, input logic [4:0] a1,
                          input logic e2, input logic [4:0] a2);
    drive(r, w, wa, wd, e1, a1, e2, a2);
    #1;
    check({tag, "_rdata1"}, rf.rdata1, exp_read(rf.re1, rf.raddr1));
    check({tag, "_rdata2"}, rf.rdata2, exp_read(rf.re2, rf.raddr2));
    check({tag, "_wr_count"}, rf.wr_count, model_cnt);
    show(tag);
    @(posedge clk);
    model_update();
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst       = 1'b1;
    rf.we     = 1'b0;
    rf.waddr  = '0;
    rf.wdata  = '0;
    rf.re1    = 1'b0;
    rf.raddr1 = '0;
    rf.re2    = 1'b0;
    rf.raddr2 = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_cnt = 32'h0;
    #1;
    check("reset_wr_count", rf.wr_count, 32'h0);
    check("reset_rdata1", rf.rdata1, 32'h0);

    // Expected values are the read/count seen before each row's clock edge.
    vecs.push_back('{1'b0, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'd0});
    vecs.push_back('{1'b1, 1'b1, 5'd5, 32'hFFFFFFFF, 1'b1, 5'd5, 1'b1, 5'd5, 32'h0, 32'h0, 32'd1});
    vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b1, 5'd5, 32'h0, 32'h0, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 5'd3, 1'b0, 5'd0,
                     BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd3, 1'b1, 5'd0, 32'hDEADBEEF, 32'h0, 32'd1});
    vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b1, 5'd0, 32'hDEADBEEF, 32'h0, 32'd1});
    vecs.push_back('{1'b0, 1'b1, 5'd7, 32'h11,       1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'd1});
    vecs.push_back('{1'b0, 1'b1, 5'd7, 32'h22,       1'b1, 5'd7, 1'b1, 5'd7,
                     BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, 32'd2});
    vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b1, 5'd7, 32'h22, 32'h22, 32'd3});
    vecs.push_back('{1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 1'b1, 5'd7,
                     BYP ? 32'hA5A5A5A5 : 32'h22, BYP ? 32'hA5A5A5A5 : 32'h22, 32'd3});
    vecs.push_back('{1'b0, 1'b1, 5'd9, 32'h55,       1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'd4});
    vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 1'b1, 5'd9, 32'h0, 32'h55, 32'd5});
    vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd5});

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].w, vecs[i].wa, vecs[i].wd,
            vecs[i].e1, vecs[i].a1, vecs[i].e2, vecs[i].a2);
      #1;
      check($sformatf("vec%0d_rdata1", i), rf.rdata1, vecs[i].x1);
      check($sformatf("vec%0d_rdata2", i), rf.rdata2, vecs[i].x2);
      check($sformatf("vec%0d_wr_count", i), rf.wr_count, vecs[i].xc);
      show($sformatf("vec%0d", i));
      @(posedge clk);
      model_update();
    end

    // Random traffic on a narrow address range to provoke collisions.
    for (int n = 0; n < 300; n++) begin
      run_step($sformatf("rnd%0d", n),
               ($urandom_range(0, 39) == 0),
               1'(($urandom_range(0, 3) != 0)),
               5'($urandom_range(0, 11)),
               32'($urandom()),
               1'(($urandom_range(0, 4) != 0)),
               5'($urandom_range(0, 11)),
               1'(($urandom_range(0, 4) != 0)),
               5'($urandom_range(0, 11)));
    end

    // Counter wrap: preload the counter, then commit one write.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    force dut.wr_count_q = 32'hFFFFFFFF;
    #1;
    release dut.wr_count_q;
    #1;
    check("wrap_preload", rf.wr_count, 32'hFFFFFFFF);
    @(posedge clk);
    model_cnt = 32'hFFFFFFFF;
    run_step("wrap_write", 1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b0, 5'd0);
    #1;
    check("wrap_to_zero", rf.wr_count, 32'h0);

    // Write presented on a reset edge must be lost.
    run_step("collide", 1'b1, 1'b1, 5'd6, 32'h77, 1'b1, 5'd6, 1'b1, 5'd4);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 5'd4);
    #1;
    check("collide_reg6", rf.rdata1, 32'h0);
    check("collide_reg4", rf.rdata2, 32'h0);
    check("collide_cnt", rf.wr_count, 32'h0);
    show("collide_after");
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
